// File: rtl/fadd_scheduler.sv
// fadd_scheduler: shares one pipelined fp adder among NREQ requesters.
// Round-robin issue, tag tracking, credit-guarded in-order response fifo.
module fadd_scheduler #(
  parameter int NREQ  = 4,
  parameter int LAT   = 3,
  parameter int DEPTH = 4,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [32*NREQ-1:0]  req_a,
  input  logic [32*NREQ-1:0]  req_b,
  output logic [31:0]         fadd_a,
  output logic [31:0]         fadd_b,
  input  logic [31:0]         fadd_y,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_y,
  output logic [IDW-1:0]      rsp_id,
  output logic                busy
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  logic [IDW-1:0] rr;
  logic [LAT:1]   tag_v;
  logic [IDW-1:0] tag_id [1:LAT];
  logic [31:0]    mem_y  [DEPTH];
  logic [IDW-1:0] mem_id [DEPTH];
  logic [PW-1:0]  wp;
  logic [PW-1:0]  rp;
  logic [OW-1:0]  occ;
  logic           pop;
  logic           wr;
  logic           issue_ok;
  logic           found;
  logic           issue;
  logic [IDW-1:0] gnt_id;
  int             inflight;
  int             idx;
  int             gsel;

  assign rsp_valid = (occ != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign wr        = tag_v[LAT];
  assign rsp_y     = mem_y[rp];
  assign rsp_id    = mem_id[rp];
  assign busy      = (occ != '0) | (|tag_v);

  // an issue now occupies a fifo slot LAT cycles later; reserve it up front
  always_comb begin
    inflight = 0;
    for (int k = 1; k <= LAT; k++)
      inflight += int'(tag_v[k]);
    issue_ok = (int'(occ) + inflight - int'(pop) + 1) <= DEPTH;
  end

  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = IDW'(idx);
      end
    end
    issue     = found & issue_ok & rstn;
    gsel      = int'(gnt_id);
    req_ready = issue ? (NREQ'(1) << gnt_id) : '0;
    fadd_a    = issue ? req_a[32*gsel +: 32] : '0;
    fadd_b    = issue ? req_b[32*gsel +: 32] : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_v <= '0;
      for (int k = 1; k <= LAT; k++)
        tag_id[k] <= '0;
    end else begin
      tag_v[1]  <= issue;
      tag_id[1] <= gnt_id;
      for (int k = 2; k <= LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
      rr  <= IDW'(NREQ - 1);
    end else begin
      if (wr)
        wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + PW'(1);
      if (pop)
        rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + PW'(1);
      if (wr && !pop)
        occ <= occ + OW'(1);
      else if (!wr && pop)
        occ <= occ - OW'(1);
      if (issue)
        rr <= gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_y[wp]  <= fadd_y;
      mem_id[wp] <= tag_id[LAT];
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && wr)
      assert (occ != OW'(DEPTH));
  end

endmodule

// File: tb/tb_fadd_scheduler.sv
// tb_fadd_scheduler: directed bench with a behavioural 3-stage fp adder.
// Sums of small integers are exact, so expected words are hand constants.
module tb_fadd_scheduler;
  localparam int NREQ  = 4;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int IDW   = 2;
  localparam logic [31:0] ONE = 32'h3F800000;
  // FV[n] is the single-precision encoding of n+1.0
  localparam logic [31:0] FV [10] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
    32'h41100000, 32'h41200000};

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_a = '0;
  logic [32*NREQ-1:0] req_b = '0;
  logic [31:0]       fadd_a;
  logic [31:0]       fadd_b;
  logic [31:0]       fadd_y;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [31:0]       rsp_y;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  int passed = 0;
  int total  = 0;

  fadd_scheduler #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .fadd_a(fadd_a), .fadd_b(fadd_b), .fadd_y(fadd_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] s2d(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:0] == 31'd0) return {x[31], 63'd0};
    e = {3'b000, x[30:23]} + 11'd896;
    return {x[31], e, x[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] d2s(input logic [63:0] d);
    logic [10:0] e;
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] f32add(input logic [31:0] a, input logic [31:0] b);
    return d2s($realtobits($bitstoreal(s2d(a)) + $bitstoreal(s2d(b))));
  endfunction

  logic [31:0] p1, p2, p3;
  always @(posedge clk) begin
    p1 <= f32add(fadd_a, fadd_b);
    p2 <= p1;
    p3 <= p2;
  end
  assign fadd_y = p3;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops;
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = FV[i];
      req_b[32*i +: 32] = ONE;
    end
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    req_valid = '1;
    set_ops();
    #2;
    total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else passed++;
    total++; if (fadd_a !== 32'd0 || fadd_b !== 32'd0) $display("FAIL reset_fadd: got %h/%h want 0/0", fadd_a, fadd_b); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    do_reset();
  endtask

  task automatic test_single;
    do_reset();
    req_valid = 4'b0001;
    req_a[31:0] = 32'h3F800000;
    req_b[31:0] = 32'h40000000;
    #2;
    total++; if (req_ready !== 4'b0001) $display("FAIL single_grant: got %b want 0001", req_ready); else passed++;
    total++; if (fadd_a !== 32'h3F800000 || fadd_b !== 32'h40000000) $display("FAIL single_fadd: got %h/%h want 3f800000/40000000", fadd_a, fadd_b); else passed++;
    step();
    req_valid = '0;
    for (int c = 1; c < 4; c++) begin
      #2;
      total++; if (rsp_valid !== 1'b0 || busy !== 1'b1) $display("FAIL single_wait c%0d: got valid=%b busy=%b want 0/1", c, rsp_valid, busy); else passed++;
      step();
    end
    #2;
    total++; if (rsp_valid !== 1'b1 || rsp_y !== 32'h40400000 || rsp_id !== 2'd0) $display("FAIL single_rsp: got v=%b y=%h id=%0d want 1/40400000/0", rsp_valid, rsp_y, rsp_id); else passed++;
    step();
    #2;
    total++; if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL single_idle: got busy=%b v=%b want 0/0", busy, rsp_valid); else passed++;
  endtask

  task automatic test_all_four;
    logic [3:0] exp_g;
    int j;
    do_reset();
    set_ops();
    req_valid = '1;
    for (int c = 0; c < 12; c++) begin
      #2;
      exp_g = 4'b0001 << (c % 4);
      total++; if (req_ready !== exp_g) $display("FAIL rr_grant c%0d: got %b want %b", c, req_ready, exp_g); else passed++;
      if (c >= 4) begin
        j = (c - 4) % 4;
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== IDW'(j) || rsp_y !== FV[j+1])
          $display("FAIL rr_rsp c%0d: got v=%b id=%0d y=%h want 1/%0d/%h", c, rsp_valid, rsp_id, rsp_y, j, FV[j+1]);
        else passed++;
      end
      step();
    end
  endtask

  task automatic test_fairness;
    logic [3:0] exp_g;
    do_reset();
    set_ops();
    req_valid = 4'b1010;
    for (int c = 0; c < 8; c++) begin
      #2;
      exp_g = (c % 2 == 0) ? 4'b0010 : 4'b1000;
      total++; if (req_ready !== exp_g) $display("FAIL fair_grant c%0d: got %b want %b", c, req_ready, exp_g); else passed++;
      step();
    end
  endtask

  task automatic test_backpressure;
    int k;
    logic [3:0]  exp_g;
    logic [31:0] exp_y;
    do_reset();
    set_ops();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    k = 0;
    for (int c = 0; c < 15; c++) begin
      if (c == 10) rsp_ready = 1'b1;
      req_a[31:0] = FV[k];
      #2;
      exp_g = (c < 4 || c >= 10) ? 4'b0001 : 4'b0000;
      total++; if (req_ready !== exp_g) $display("FAIL bp_grant c%0d: got %b want %b", c, req_ready, exp_g); else passed++;
      if (c >= 4) begin
        exp_y = (c < 10) ? FV[1] : FV[c-9];
        total++;
        if (rsp_valid !== 1'b1 || rsp_y !== exp_y || rsp_id !== 2'd0)
          $display("FAIL bp_rsp c%0d: got v=%b y=%h id=%0d want 1/%h/0", c, rsp_valid, rsp_y, rsp_id, exp_y);
        else passed++;
      end
      if (req_ready[0]) k++;
      step();
    end
  endtask

  task automatic test_reset_mid;
    int nresp;
    do_reset();
    set_ops();
    req_valid = '1;
    #2;
    total++; if (req_ready !== 4'b0001) $display("FAIL rst_pre_grant: got %b want 0001", req_ready); else passed++;
    step();
    step();
    #2;
    total++; if (busy !== 1'b1) $display("FAIL rst_pre_busy: got %b want 1", busy); else passed++;
    #1;
    rstn = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) $display("FAIL rst_async: got v=%b busy=%b rdy=%b want 0/0/0000", rsp_valid, busy, req_ready); else passed++;
    step();
    step();
    rstn = 1'b1;
    #2;
    total++; if (req_ready !== 4'b0001) $display("FAIL rst_post_grant: got %b want 0001", req_ready); else passed++;
    step();
    req_valid = '0;
    nresp = 0;
    for (int c = 0; c < 12; c++) begin
      #2;
      if (rsp_valid === 1'b1) begin
        nresp++;
        total++; if (rsp_y !== FV[1] || rsp_id !== 2'd0) $display("FAIL rst_post_rsp: got y=%h id=%0d want %h/0", rsp_y, rsp_id, FV[1]); else passed++;
      end
      step();
    end
    total++; if (nresp != 1) $display("FAIL rst_resp_count: got %0d want 1", nresp); else passed++;
  endtask

  task automatic test_full_boundary;
    logic [33:0] sb [$];
    logic [33:0] e;
    int issued;
    int popped;
    int maxout;
    do_reset();
    set_ops();
    req_valid = '1;
    issued = 0;
    popped = 0;
    maxout = 0;
    for (int c = 0; c < 70; c++) begin
      if (c >= 40) req_valid = '0;
      rsp_ready = (c >= 40) ? 1'b1 : (c % 2 == 0);
      #2;
      if (rsp_valid === 1'b1 && rsp_ready) begin
        popped++;
        total++;
        if (sb.size() == 0) $display("FAIL full_extra_rsp: got y=%h id=%0d want none", rsp_y, rsp_id);
        else begin
          e = sb.pop_front();
          if ({rsp_y, rsp_id} !== e) $display("FAIL full_order: got %h/%0d want %h/%0d", rsp_y, rsp_id, e[33:2], e[1:0]);
          else passed++;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && req_valid[i]) begin
          sb.push_back({FV[i+1], 2'(i)});
          issued++;
        end
      end
      if (issued - popped > maxout) maxout = issued - popped;
      step();
    end
    #2;
    total++; if (sb.size() != 0 || issued != popped) $display("FAIL full_drain: got left=%0d issued=%0d popped=%0d want 0 left", sb.size(), issued, popped); else passed++;
    total++; if (maxout > DEPTH) $display("FAIL full_outstanding: got %0d want <= %0d", maxout, DEPTH); else passed++;
    total++; if (issued < 10) $display("FAIL full_progress: got %0d issues want >= 10", issued); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL full_idle: got busy=%b want 0", busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_full_boundary();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
